// File: rtl/dmem_sram_bridge_if.sv
// Request/response channel between the multi-cycle CPU and the data-memory bridge.
// The CPU drives the master side; the bridge implements the slave side.
interface dmem_sram_bridge_if;
   logic [31:0] Address;
   logic        MemWrite;
   logic [31:0] Write_data;
   logic [3:0]  Write_strb;
   logic        MemRead;
   logic        Mem_Req_Ready;
   logic [31:0] Read_data;
   logic        Read_data_Valid;
   logic        Read_data_Ready;

   modport master (
      output Address, MemWrite, Write_data, Write_strb, MemRead, Read_data_Ready,
      input  Mem_Req_Ready, Read_data, Read_data_Valid
   );

   modport slave (
      input  Address, MemWrite, Write_data, Write_strb, MemRead, Read_data_Ready,
      output Mem_Req_Ready, Read_data, Read_data_Valid
   );
endinterface

// File: rtl/dmem_sram_bridge.sv
// Word-addressed data SRAM with byte-strobed writes and fixed-latency valid/ready reads.
// Define DMEM_BRIDGE_PERF_CNT_EN to add read/write/stall performance counters.
module dmem_sram_bridge #(
   parameter int DEPTH_LOG2 = 10,
   parameter int RD_LAT     = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   dmem_sram_bridge_if.slave    bus
`ifdef DMEM_BRIDGE_PERF_CNT_EN
   ,
   output logic [31:0]          perf_rd_cnt,
   output logic [31:0]          perf_wr_cnt,
   output logic [31:0]          perf_stall_cnt
`endif
);
   typedef enum logic [1:0] {IDLE, RD_WAIT, RD_RESP} state_t;

   localparam logic [3:0] LAT_M1 = 4'(RD_LAT - 1);

   state_t                state, state_nxt;
   logic [3:0]            counter, counter_nxt;
   logic [DEPTH_LOG2-1:0] word_idx, rd_idx, load_idx;
   logic [31:0]           mem [2**DEPTH_LOG2];
   logic [31:0]           rd_data;
   logic                  rd_valid, valid_nxt;
   logic                  req_ready, wr_acc, rd_acc, load_rd;
   logic                  unused_addr;

   assign word_idx    = bus.Address[DEPTH_LOG2+1:2];
   assign unused_addr = ^{bus.Address[31:DEPTH_LOG2+2], bus.Address[1:0]};

   // Ready is gated by rst so nothing is accepted while the block is held in reset.
   assign req_ready = (state == IDLE) && rst;
   assign wr_acc    = req_ready && bus.MemWrite;
   assign rd_acc    = req_ready && bus.MemRead && !bus.MemWrite;

   assign bus.Mem_Req_Ready   = req_ready;
   assign bus.Read_data       = rd_data;
   assign bus.Read_data_Valid = rd_valid;

   always_comb begin
      state_nxt   = state;
      counter_nxt = counter;
      valid_nxt   = rd_valid;
      load_rd     = 1'b0;
      load_idx    = rd_idx;
      unique case (state)
         IDLE: begin
            if (rd_acc) begin
               load_idx = word_idx;
               if (RD_LAT == 1) begin
                  state_nxt = RD_RESP;
                  load_rd   = 1'b1;
                  valid_nxt = 1'b1;
               end else begin
                  state_nxt   = RD_WAIT;
                  counter_nxt = LAT_M1;
               end
            end
         end
         RD_WAIT: begin
            counter_nxt = counter - 4'd1;
            if (counter == 4'd1) begin
               state_nxt = RD_RESP;
               load_rd   = 1'b1;
               valid_nxt = 1'b1;
            end
         end
         RD_RESP: begin
            if (bus.Read_data_Ready) begin
               state_nxt = IDLE;
               valid_nxt = 1'b0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         counter  <= 4'd0;
         rd_valid <= 1'b0;
         rd_data  <= 32'd0;
      end else begin
         state    <= state_nxt;
         counter  <= counter_nxt;
         rd_valid <= valid_nxt;
         if (load_rd) rd_data <= mem[load_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (rd_acc) rd_idx <= word_idx;
   end

   // Storage is deliberately not reset; a write commits at its accept edge.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (wr_acc && bus.Write_strb[i]) mem[word_idx][8*i +: 8] <= bus.Write_data[8*i +: 8];
      end
   end

`ifdef DMEM_BRIDGE_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         perf_rd_cnt    <= 32'd0;
         perf_wr_cnt    <= 32'd0;
         perf_stall_cnt <= 32'd0;
      end else begin
         if (rd_acc) perf_rd_cnt <= perf_rd_cnt + 32'd1;
         if (wr_acc) perf_wr_cnt <= perf_wr_cnt + 32'd1;
         if ((bus.MemRead || bus.MemWrite) && !req_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
   end
`endif
endmodule
